// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer for the 6502 core.
// Gathers reset, NMI, IRQ and BRK requests, picks one by priority at each instruction
// boundary and holds the select vector, vector address and B flag steady for the
// control FSM's shared BRK/interrupt sequence until the vector fetch completes.
module interrupt_sequencer #(
    parameter int unsigned NMI_SYNC = 2,
    parameter logic [15:0] VEC_NMI  = 16'hFFFA,
    parameter logic [15:0] VEC_RST  = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ  = 16'hFFFE
) (
    input  logic        i_phi1,
    input  logic        i_rst,
    input  logic        i_nmi_n,
    input  logic        i_irq_n,
    input  logic        i_rdy,
    input  logic        i_t1now,
    input  logic        i_brk_op,
    input  logic        i_i_flag,
    input  logic        i_vec_fetch,
    input  logic        i_vec_done,
    output logic        o_int_req,
    output logic [3:0]  o_int_sel,
    output logic [15:0] o_vec_addr,
    output logic        o_b_flag,
    output logic        o_nmi_pend
);

    typedef enum logic [1:0] {
        StRstSeq,
        StIdle,
        StService,
        StLocked
    } state_e;

    localparam logic [3:0] SelRst = 4'b0001;
    localparam logic [3:0] SelNmi = 4'b0010;
    localparam logic [3:0] SelIrq = 4'b0100;
    localparam logic [3:0] SelBrk = 4'b1000;

    state_e        r_state;
    logic          r_int_req;
    logic [3:0]    r_int_sel;
    logic [15:0]   r_vec_addr;
    logic          r_b_flag;
    logic          r_nmi_pend;

    // Bits [NMI_SYNC-1:0] are the synchronizer; bit NMI_SYNC is the previous synced
    // value used for falling-edge detection.
    logic [NMI_SYNC:0] r_nmi_sync;

    logic w_nmi_edge;
    logic w_nmi_any;
    logic w_irq;
    logic w_hijackable;

    assign w_nmi_edge   = r_nmi_sync[NMI_SYNC] & ~r_nmi_sync[NMI_SYNC-1];
    // An edge seen in the accepting cycle counts as pending and is consumed with it.
    assign w_nmi_any    = r_nmi_pend | w_nmi_edge;
    assign w_irq        = ~i_irq_n & ~i_i_flag;
    assign w_hijackable = r_int_sel[2] | r_int_sel[3];

    // NMI synchronizer and edge history; runs regardless of rdy and state.
    always_ff @(posedge i_phi1 or negedge i_rst) begin
        if (!i_rst) begin
            r_nmi_sync <= '1;
        end else begin
            r_nmi_sync <= {r_nmi_sync[NMI_SYNC-1:0], i_nmi_n};
        end
    end

    // Sequencer FSM with registered outputs and NMI pending latch.
    always_ff @(posedge i_phi1 or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= StRstSeq;
            r_int_req  <= 1'b1;
            r_int_sel  <= SelRst;
            r_vec_addr <= VEC_RST;
            r_b_flag   <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            // Edges latch even while rdy is low; acceptance below may override.
            if (w_nmi_edge) begin
                r_nmi_pend <= 1'b1;
            end
            if (i_rdy) begin
                unique case (r_state)
                    StRstSeq: begin
                        if (i_vec_done) begin
                            r_state    <= StIdle;
                            r_int_req  <= 1'b0;
                            r_int_sel  <= 4'b0000;
                            r_vec_addr <= VEC_IRQ;
                        end
                    end
                    StIdle: begin
                        if (i_t1now) begin
                            if (w_nmi_any) begin
                                r_state    <= StService;
                                r_int_req  <= 1'b1;
                                r_int_sel  <= SelNmi;
                                r_vec_addr <= VEC_NMI;
                                r_b_flag   <= 1'b0;
                                r_nmi_pend <= 1'b0;
                            end else if (w_irq) begin
                                r_state    <= StService;
                                r_int_req  <= 1'b1;
                                r_int_sel  <= SelIrq;
                                r_vec_addr <= VEC_IRQ;
                                r_b_flag   <= 1'b0;
                            end else if (i_brk_op) begin
                                r_state    <= StService;
                                r_int_req  <= 1'b1;
                                r_int_sel  <= SelBrk;
                                r_vec_addr <= VEC_IRQ;
                                r_b_flag   <= 1'b1;
                            end
                        end
                    end
                    StService: begin
                        if (i_vec_fetch) begin
                            r_state <= StLocked;
                        end else if (w_nmi_any && w_hijackable) begin
                            // Hijack keeps b_flag so a hijacked BRK still pushes B=1.
                            r_int_sel  <= SelNmi;
                            r_vec_addr <= VEC_NMI;
                            r_nmi_pend <= 1'b0;
                        end
                    end
                    StLocked: begin
                        if (i_vec_done) begin
                            r_state   <= StIdle;
                            r_int_req <= 1'b0;
                            r_int_sel <= 4'b0000;
                        end
                    end
                    default: begin
                        r_state <= StRstSeq;
                    end
                endcase
            end
        end
    end

    assign o_int_req  = r_int_req;
    assign o_int_sel  = r_int_sel;
    assign o_vec_addr = r_vec_addr;
    assign o_b_flag   = r_b_flag;
    assign o_nmi_pend = r_nmi_pend;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer: directed scenarios plus a randomized run checked
// against a transaction-level reference model.
module tb_interrupt_sequencer;

    localparam int unsigned NS      = 2;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        nmi_n     = 1'b1;
    logic        irq_n     = 1'b1;
    logic        rdy       = 1'b1;
    logic        t1now     = 1'b0;
    logic        brk_op    = 1'b0;
    logic        i_flag    = 1'b1;
    logic        vec_fetch = 1'b0;
    logic        vec_done  = 1'b0;
    logic        int_req;
    logic [3:0]  int_sel;
    logic [15:0] vec_addr;
    logic        b_flag;
    logic        nmi_pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interrupt_sequencer #(
        .NMI_SYNC (NS),
        .VEC_NMI  (VEC_NMI),
        .VEC_RST  (VEC_RST),
        .VEC_IRQ  (VEC_IRQ)
    ) dut (
        .i_phi1      (clk),
        .i_rst       (rst),
        .i_nmi_n     (nmi_n),
        .i_irq_n     (irq_n),
        .i_rdy       (rdy),
        .i_t1now     (t1now),
        .i_brk_op    (brk_op),
        .i_i_flag    (i_flag),
        .i_vec_fetch (vec_fetch),
        .i_vec_done  (vec_done),
        .o_int_req   (int_req),
        .o_int_sel   (int_sel),
        .o_vec_addr  (vec_addr),
        .o_b_flag    (b_flag),
        .o_nmi_pend  (nmi_pend)
    );

    // Reference model: which request is being serviced (0 RST, 1 NMI, 2 IRQ, 3 BRK,
    // -1 none) and how far the vector fetch has progressed.
    int          m_phase;  // 0 reset sequence, 1 idle, 2 before fetch, 3 after fetch
    int          m_kind;
    logic        m_req;
    logic [15:0] m_vec;
    logic        m_b;
    logic        m_pend;
    bit          pin_hist[$];  // nmi_n sampled at each edge, oldest first

    function automatic logic [3:0] sel_of(int k);
        if (k < 0) return 4'b0000;
        return 4'(1 << k);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_kind  = 0;
        m_req   = 1'b1;
        m_vec   = VEC_RST;
        m_b     = 1'b0;
        m_pend  = 1'b0;
        pin_hist.delete();
        for (int i = 0; i <= NS; i++) pin_hist.push_back(1'b1);
    endtask

    task automatic model_edge();
        bit edge_now;
        bit consumed;
        int want;
        if (!rst) begin
            model_reset();
            return;
        end
        // Falling edge as seen NS samples late.
        edge_now = (pin_hist[pin_hist.size() - 1 - NS] == 1'b1) &&
                   (pin_hist[pin_hist.size() - NS] == 1'b0);
        consumed = 1'b0;
        if (rdy) begin
            case (m_phase)
                0: if (vec_done) begin
                    m_phase = 1; m_kind = -1; m_req = 1'b0; m_vec = VEC_IRQ;
                end
                1: if (t1now) begin
                    want = -1;
                    if (brk_op) want = 3;
                    if (!irq_n && !i_flag) want = 2;
                    if (m_pend || edge_now) want = 1;
                    if (want > 0) begin
                        m_phase  = 2;
                        m_kind   = want;
                        m_req    = 1'b1;
                        m_vec    = (want == 1) ? VEC_NMI : VEC_IRQ;
                        m_b      = (want == 3);
                        consumed = (want == 1);
                    end
                end
                2: if (vec_fetch) begin
                    m_phase = 3;
                end else if ((m_pend || edge_now) && m_kind >= 2) begin
                    m_kind = 1; m_vec = VEC_NMI; consumed = 1'b1;
                end
                3: if (vec_done) begin
                    m_phase = 1; m_kind = -1; m_req = 1'b0;
                end
                default: ;
            endcase
        end
        m_pend = consumed ? 1'b0 : (m_pend | edge_now);
        pin_hist.push_back(nmi_n);
        void'(pin_hist.pop_front());
    endtask

    // One clock: model follows the same edge, outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet_inputs();
        irq_n = 1'b1; rdy = 1'b1; t1now = 1'b0; brk_op = 1'b0;
        i_flag = 1'b1; vec_fetch = 1'b0; vec_done = 1'b0;
    endtask

    task automatic finish_service();
        vec_fetch = 1'b1; tick(); vec_fetch = 1'b0;
        vec_done = 1'b1; tick(); vec_done = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        model_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL por_req got %b want 1", int_req); end
        checks++; if (int_sel !== 4'b0001) begin errors++; $display("FAIL por_sel got %b want 0001", int_sel); end
        checks++; if (vec_addr !== VEC_RST) begin errors++; $display("FAIL por_vec got %h want %h", vec_addr, VEC_RST); end
        checks++; if (b_flag !== 1'b0 || nmi_pend !== 1'b0) begin errors++; $display("FAIL por_b_pend got %b%b want 00", b_flag, nmi_pend); end
        tick(); tick();
        rst = 1'b1; vec_done = 1'b1; tick(); vec_done = 1'b0;
        checks++; if (int_req !== 1'b0 || int_sel !== 4'b0000) begin errors++; $display("FAIL rstseq_exit got %b/%b want 0/0000", int_req, int_sel); end
        checks++; if (vec_addr !== VEC_IRQ) begin errors++; $display("FAIL rstseq_vec got %h want %h", vec_addr, VEC_IRQ); end
    endtask

    task automatic test_reset_mid_service();
        t1now = 1'b1; brk_op = 1'b1; tick(); t1now = 1'b0; brk_op = 1'b0;
        rdy = 1'b0; nmi_n = 1'b0;
        tick(); tick(); tick();
        checks++; if (nmi_pend !== 1'b1 || int_sel !== 4'b1000) begin errors++; $display("FAIL stall_pend got %b/%b want 1/1000", nmi_pend, int_sel); end
        #2 rst = 1'b0;
        #1;
        checks++; if (int_sel !== 4'b0001 || int_req !== 1'b1) begin errors++; $display("FAIL midrst_sel got %b/%b want 0001/1", int_sel, int_req); end
        checks++; if (vec_addr !== VEC_RST) begin errors++; $display("FAIL midrst_vec got %h want %h", vec_addr, VEC_RST); end
        checks++; if (nmi_pend !== 1'b0 || b_flag !== 1'b0) begin errors++; $display("FAIL midrst_pend got %b/%b want 0/0", nmi_pend, b_flag); end
        nmi_n = 1'b1; rdy = 1'b1;
        tick();
        rst = 1'b1; vec_done = 1'b1; tick(); vec_done = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL midrst_exit got %b want 0", int_req); end
    endtask

    task automatic test_nmi_held();
        nmi_n = 1'b0;
        tick(); tick();
        checks++; if (nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_early got %b want 0", nmi_pend); end
        tick();
        checks++; if (nmi_pend !== 1'b1) begin errors++; $display("FAIL nmi_latency got %b want 1", nmi_pend); end
        t1now = 1'b1; tick(); t1now = 1'b0;
        checks++; if (int_sel !== 4'b0010 || vec_addr !== VEC_NMI) begin errors++; $display("FAIL nmi_accept got %b/%h want 0010/%h", int_sel, vec_addr, VEC_NMI); end
        checks++; if (nmi_pend !== 1'b0 || int_req !== 1'b1 || b_flag !== 1'b0) begin errors++; $display("FAIL nmi_accept_flags got %b%b%b want 010", nmi_pend, int_req, b_flag); end
        finish_service();
        t1now = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        t1now = 1'b0;
        checks++; if (int_req !== 1'b0 || nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_single got %b/%b want 0/0", int_req, nmi_pend); end
        nmi_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_irq();
        irq_n = 1'b0; i_flag = 1'b1; t1now = 1'b1; tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", int_req); end
        i_flag = 1'b0; tick();
        checks++; if (int_req !== 1'b1 || int_sel !== 4'b0100) begin errors++; $display("FAIL irq_accept got %b/%b want 1/0100", int_req, int_sel); end
        checks++; if (vec_addr !== VEC_IRQ || b_flag !== 1'b0) begin errors++; $display("FAIL irq_vec got %h/%b want %h/0", vec_addr, b_flag, VEC_IRQ); end
        quiet_inputs();
        finish_service();
    endtask

    task automatic test_brk_hijack();
        t1now = 1'b1; brk_op = 1'b1; tick(); t1now = 1'b0; brk_op = 1'b0;
        checks++; if (int_sel !== 4'b1000 || b_flag !== 1'b1) begin errors++; $display("FAIL brk_accept got %b/%b want 1000/1", int_sel, b_flag); end
        nmi_n = 1'b0; tick(); tick();
        checks++; if (int_sel !== 4'b1000) begin errors++; $display("FAIL brk_prehijack got %b want 1000", int_sel); end
        tick();
        checks++; if (int_sel !== 4'b0010 || vec_addr !== VEC_NMI) begin errors++; $display("FAIL hijack got %b/%h want 0010/%h", int_sel, vec_addr, VEC_NMI); end
        checks++; if (b_flag !== 1'b1 || nmi_pend !== 1'b0) begin errors++; $display("FAIL hijack_flags got %b/%b want 1/0", b_flag, nmi_pend); end
        nmi_n = 1'b1;
        finish_service();
        for (int i = 0; i < 3; i++) tick();
        t1now = 1'b1; brk_op = 1'b1; tick(); t1now = 1'b0; brk_op = 1'b0;
        vec_fetch = 1'b1; tick(); vec_fetch = 1'b0;
        nmi_n = 1'b0; tick(); tick(); tick();
        checks++; if (vec_addr !== VEC_IRQ || int_sel !== 4'b1000) begin errors++; $display("FAIL locked_nohijack got %h/%b want %h/1000", vec_addr, int_sel, VEC_IRQ); end
        checks++; if (nmi_pend !== 1'b1) begin errors++; $display("FAIL locked_pend got %b want 1", nmi_pend); end
        vec_done = 1'b1; tick(); vec_done = 1'b0;
        checks++; if (int_req !== 1'b0 || nmi_pend !== 1'b1) begin errors++; $display("FAIL locked_exit got %b/%b want 0/1", int_req, nmi_pend); end
        t1now = 1'b1; tick(); t1now = 1'b0;
        checks++; if (int_sel !== 4'b0010 || vec_addr !== VEC_NMI || nmi_pend !== 1'b0) begin errors++; $display("FAIL deferred_nmi got %b/%h/%b want 0010/%h/0", int_sel, vec_addr, nmi_pend, VEC_NMI); end
        nmi_n = 1'b1;
        finish_service();
        tick();
    endtask

    task automatic test_rdy();
        rdy = 1'b0; t1now = 1'b1; irq_n = 1'b0; i_flag = 1'b0;
        tick(); tick(); tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rdy_hold got %b want 0", int_req); end
        rdy = 1'b1; tick();
        checks++; if (int_req !== 1'b1 || int_sel !== 4'b0100) begin errors++; $display("FAIL rdy_release got %b/%b want 1/0100", int_req, int_sel); end
        quiet_inputs();
        finish_service();
    endtask

    task automatic test_priority();
        nmi_n = 1'b0; tick(); tick(); tick();
        checks++; if (nmi_pend !== 1'b1) begin errors++; $display("FAIL prio_pend got %b want 1", nmi_pend); end
        irq_n = 1'b0; i_flag = 1'b0; brk_op = 1'b1; t1now = 1'b1; tick();
        checks++; if (int_sel !== 4'b0010 || b_flag !== 1'b0 || nmi_pend !== 1'b0) begin errors++; $display("FAIL prio_nmi got %b/%b/%b want 0010/0/0", int_sel, b_flag, nmi_pend); end
        quiet_inputs();
        finish_service();
        nmi_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
            irq_n     = ($urandom_range(0, 2) != 0);
            rdy       = ($urandom_range(0, 4) != 0);
            t1now     = ($urandom_range(0, 2) == 0);
            brk_op    = ($urandom_range(0, 4) == 0);
            i_flag    = ($urandom_range(0, 1) == 0);
            vec_fetch = ($urandom_range(0, 2) == 0);
            vec_done  = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if (int_req !== m_req || int_sel !== sel_of(m_kind) || vec_addr !== m_vec ||
                b_flag !== m_b || nmi_pend !== m_pend) begin
                errors++;
                if (bad < 10) $display("FAIL rand_cycle%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b",
                    n, int_req, int_sel, vec_addr, b_flag, nmi_pend,
                    m_req, sel_of(m_kind), m_vec, m_b, m_pend);
                bad++;
            end
        end
        rst = 1'b1;
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_mid_service();
        test_nmi_held();
        test_irq();
        test_brk_hijack();
        test_rdy();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
